// File: rtl/regfile_writeback_if.sv
// Result-push channel from the execution units into the write-back queue.
//   in_valid : result offered (master -> slave)
//   in_ready : queue can accept (slave -> master)
//   in_addr  : destination register index
//   in_data  : result word
// master = producing execution unit, slave = regfile_writeback.
`ifndef WIDTH_SEG
`define WIDTH_SEG 5
`endif
`ifndef WIDTH_WORD
`define WIDTH_WORD 32
`endif

interface regfile_writeback_if #(
  parameter int AW = `WIDTH_SEG,
  parameter int DW = `WIDTH_WORD
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_writeback.sv
// Write-side feeder for a dual-write-port register file.
// Results arrive one per cycle on s_in, are queued in order, and drain up to
// two per cycle onto write0/write1. Two scoreboard query ports report whether
// any queued write still targets a given register.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_in                : push channel (valid/ready, addr, data)
//   i_hold              : suppress all writes this cycle (queue does not drain)
//   o_write0/1          : write enables, ports 0/1
//   o_waddr0/1          : write indices, ports 0/1
//   o_wdata0/1          : write data, ports 0/1
//   i_qaddr0/1          : scoreboard query indices
//   o_qbusy0/1          : a queued write targets the query index
//   o_level             : occupied entries
`ifndef WIDTH_SEG
`define WIDTH_SEG 5
`endif
`ifndef WIDTH_WORD
`define WIDTH_WORD 32
`endif

// One scoreboard query lane: OR of address matches over occupied entries.
module regfile_writeback_sb_lane #(
  parameter int DEPTH = 4,
  parameter int AW    = `WIDTH_SEG
) (
  input  logic                      i_rst,
  input  logic [DEPTH-1:0]          i_occ,
  input  logic [DEPTH-1:0][AW-1:0]  i_addr,
  input  logic [AW-1:0]             i_qaddr,
  output logic                      o_busy
);
  always_comb begin
    o_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (i_occ[i] && (i_addr[i] == i_qaddr)) o_busy = 1'b1;
    if (i_rst) o_busy = 1'b0;
  end
endmodule

module regfile_writeback #(
  parameter  int DEPTH = 4,
  parameter  int AW    = `WIDTH_SEG,
  parameter  int DW    = `WIDTH_WORD,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_writeback_if.slave  s_in,
  input  logic                i_hold,
  output logic                o_write0,
  output logic [AW-1:0]       o_waddr0,
  output logic [DW-1:0]       o_wdata0,
  output logic                o_write1,
  output logic [AW-1:0]       o_waddr1,
  output logic [DW-1:0]       o_wdata1,
  input  logic [AW-1:0]       i_qaddr0,
  output logic                o_qbusy0,
  input  logic [AW-1:0]       i_qaddr1,
  output logic                o_qbusy1,
  output logic [CW-1:0]       o_level
);
  localparam int NQ = 2;

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [PW-1:0]            r_head, r_tail;
  logic [CW-1:0]            r_count;

  logic                     w_push, w_en;
  logic [PW-1:0]            w_head1;
  logic [CW-1:0]            w_pops;
  logic [DEPTH-1:0][PW-1:0] w_rel;
  logic [DEPTH-1:0]         w_occ;
  logic [NQ-1:0][AW-1:0]    w_qaddr;
  logic [NQ-1:0]            w_qbusy;

  // Ready looks only at the registered count: a full queue refuses input
  // even in a cycle where it is draining.
  assign s_in.in_ready = !rst && (r_count != CW'(DEPTH));
  assign w_push        = s_in.in_valid && s_in.in_ready;

  assign w_en    = !i_hold && !rst;
  assign w_head1 = r_head + PW'(1);

  // Port 1 only issues when its target differs from port 0; otherwise the
  // newer entry waits and goes out on port 0 next cycle, keeping order.
  assign o_write0 = w_en && (r_count != '0);
  assign o_write1 = w_en && (r_count >= CW'(2)) && (r_addr[w_head1] != r_addr[r_head]);
  assign o_waddr0 = r_addr[r_head];
  assign o_wdata0 = r_data[r_head];
  assign o_waddr1 = r_addr[w_head1];
  assign o_wdata1 = r_data[w_head1];
  assign w_pops   = CW'(o_write0) + CW'(o_write1);
  assign o_level  = r_count;

  // Entry g is occupied when its distance from head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_occ
    assign w_rel[g] = PW'(g) - r_head;
    assign w_occ[g] = {1'b0, w_rel[g]} < r_count;
  end

  assign w_qaddr = {i_qaddr1, i_qaddr0};
  for (genvar g = 0; g < NQ; g++) begin : g_sb
    regfile_writeback_sb_lane #(.DEPTH(DEPTH), .AW(AW)) u_sb (
      .i_rst   (rst),
      .i_occ   (w_occ),
      .i_addr  (r_addr),
      .i_qaddr (w_qaddr[g]),
      .o_busy  (w_qbusy[g])
    );
  end
  assign o_qbusy0 = w_qbusy[0];
  assign o_qbusy1 = w_qbusy[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      r_head  <= r_head + PW'(w_pops);
      r_count <= r_count + CW'(w_push) - w_pops;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= s_in.in_addr;
      r_data[r_tail] <= s_in.in_data;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          write0, write1, qbusy0, qbusy1;
  logic [AW-1:0] waddr0, waddr1, qaddr0, qaddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [CW-1:0] level;

  regfile_writeback_if #(.AW(AW), .DW(DW)) bus ();

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .s_in(bus), .i_hold(hold),
    .o_write0(write0), .o_waddr0(waddr0), .o_wdata0(wdata0),
    .o_write1(write1), .o_waddr1(waddr1), .o_wdata1(wdata1),
    .i_qaddr0(qaddr0), .o_qbusy0(qbusy0),
    .i_qaddr1(qaddr1), .o_qbusy1(qbusy1),
    .o_level(level)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered list of pending writes plus a register file
  // image built from whatever the DUT writes.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] rf [32];

  always @(negedge clk) begin
    int  n;
    bit  e_rdy, e_w0, e_w1, e_b0, e_b1;
    n     = mq.size();
    e_rdy = !rst && (n < DEPTH);
    e_w0  = !rst && !hold && (n >= 1);
    e_w1  = 1'b0;
    if (!rst && !hold && n >= 2) e_w1 = (mq[1].a != mq[0].a);
    e_b0 = 1'b0;
    e_b1 = 1'b0;
    if (!rst)
      foreach (mq[i]) begin
        if (mq[i].a == qaddr0) e_b0 = 1'b1;
        if (mq[i].a == qaddr1) e_b1 = 1'b1;
      end
    chk("m_ready",  bus.in_ready, e_rdy);
    chk("m_level",  level, n);
    chk("m_write0", write0, e_w0);
    chk("m_write1", write1, e_w1);
    chk("m_qbusy0", qbusy0, e_b0);
    chk("m_qbusy1", qbusy1, e_b1);
    if (e_w0) begin
      chk("m_waddr0", waddr0, mq[0].a);
      chk("m_wdata0", wdata0, mq[0].d);
    end
    if (e_w1) begin
      chk("m_waddr1", waddr1, mq[1].a);
      chk("m_wdata1", wdata1, mq[1].d);
    end
    if (write0) rf[waddr0] = wdata0;
    if (write1) rf[waddr1] = wdata1;
    // advance the model to the state after the coming edge
    if (rst) mq.delete();
    else begin
      if (e_w0) void'(mq.pop_front());
      if (e_w1) void'(mq.pop_front());
      if (bus.in_valid && e_rdy) mq.push_back('{a: bus.in_addr, d: bus.in_data});
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.in_valid = 1'b1; bus.in_addr = a; bus.in_data = d;
  endtask

  task automatic burst();
    hold = 1'b1;
    offer(1, 32'h11); tick();
    offer(2, 32'h22); tick();
    offer(4, 32'h44); tick();
    offer(6, 32'h66); tick();
    offer(7, 32'h77);
    mid(); chk("full_level", level, 4); chk("full_ready", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0; hold = 1'b0;
    mid(); chk("refused_level", level, 4);
    chk("d1_w0", write0, 1); chk("d1_a0", waddr0, 1); chk("d1_d0", wdata0, 32'h11);
    chk("d1_w1", write1, 1); chk("d1_a1", waddr1, 2); chk("d1_d1", wdata1, 32'h22);
    tick();
    mid();
    chk("d2_w0", write0, 1); chk("d2_a0", waddr0, 4); chk("d2_d0", wdata0, 32'h44);
    chk("d2_w1", write1, 1); chk("d2_a1", waddr1, 6); chk("d2_d1", wdata1, 32'h66);
    tick();
    mid(); chk("drained_level", level, 0); chk("drained_ready", bus.in_ready, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // 1. reset with an offer pending
    rst = 1'b1; hold = 1'b0; qaddr0 = '0; qaddr1 = '0;
    offer(3, 32'hDEAD);
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("rst_w0", write0, 0); chk("rst_w1", write1, 0); chk("rst_ready", bus.in_ready, 0);
      tick();
    end
    rst = 1'b0; bus.in_valid = 1'b0;
    mid(); chk("post_rst_ready", bus.in_ready, 1); chk("post_rst_level", level, 0);
    chk("post_rst_w0", write0, 0);
    tick();

    // 2. single push
    offer(3, 32'hBEEF);
    mid(); chk("no_bypass_w0", write0, 0);
    tick();
    bus.in_valid = 1'b0;
    mid();
    chk("single_w0", write0, 1); chk("single_a0", waddr0, 3); chk("single_d0", wdata0, 32'hBEEF);
    chk("single_w1", write1, 0); chk("single_level", level, 1);
    tick();
    mid(); chk("single_after", level, 0);
    tick();

    // 3. fill and dual drain, twice so the pointers wrap
    burst();
    burst();

    // 4. same-address pair
    hold = 1'b1;
    offer(5, 32'hA); tick();
    offer(5, 32'hB); tick();
    offer(9, 32'hC); tick();
    bus.in_valid = 1'b0; hold = 1'b0;
    mid();
    chk("same1_w0", write0, 1); chk("same1_a0", waddr0, 5); chk("same1_d0", wdata0, 32'hA);
    chk("same1_w1", write1, 0);
    tick();
    mid();
    chk("same2_a0", waddr0, 5); chk("same2_d0", wdata0, 32'hB);
    chk("same2_w1", write1, 1); chk("same2_a1", waddr1, 9); chk("same2_d1", wdata1, 32'hC);
    tick();
    mid(); chk("reg5_final", rf[5], 32'hB); chk("same_level", level, 0);
    tick();

    // 5. scoreboard
    hold = 1'b1; qaddr0 = 7; qaddr1 = 8;
    offer(7, 32'h70); tick();
    bus.in_valid = 1'b0;
    mid(); chk("sb_busy0", qbusy0, 1); chk("sb_busy1", qbusy1, 0);
    tick();
    hold = 1'b0;
    mid(); chk("sb_issue_w0", write0, 1); chk("sb_issue_busy0", qbusy0, 1);
    tick();
    mid(); chk("sb_after_busy0", qbusy0, 0);
    tick();

    // 6. reset mid-operation
    hold = 1'b1; qaddr0 = 2;
    offer(1, 32'h1); tick();
    offer(2, 32'h2); tick();
    offer(3, 32'h3); tick();
    bus.in_valid = 1'b0;
    mid(); chk("mr_level", level, 3); chk("mr_busy0", qbusy0, 1);
    tick();
    rst = 1'b1; hold = 1'b0;
    mid(); chk("mr_w0", write0, 0); chk("mr_w1", write1, 0); chk("mr_busy_rst", qbusy0, 0);
    tick();
    rst = 1'b0;
    mid(); chk("mr_level0", level, 0); chk("mr_busy_after", qbusy0, 0);
    tick();
    offer(12, 32'h1234); tick();
    bus.in_valid = 1'b0;
    mid(); chk("mr_next_w0", write0, 1); chk("mr_next_a0", waddr0, 12);
    chk("mr_next_d0", wdata0, 32'h1234);
    tick();

    // streaming without hold, consecutive pairs share an address
    for (int i = 0; i < 10; i++) begin
      offer(AW'(i / 2), DW'(32'h100 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (6) tick();
    mid(); chk("stream_level", level, 0); chk("stream_reg4", rf[4], 32'h109);
    chk("stream_reg0", rf[0], 32'h101);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
